ident_emitter: RTL and testbench
================================

# ident_emitter

Transmit-side counterpart of the identifier-recognising character checker: it generates a byte-serial stream of ASCII characters that always forms a legal identifier (first character a letter, remaining characters letters or digits). It drives recogniser benches and character-stream consumers one character per accepted beat over a valid/ready handshake. Character choice is pseudo-random from a seeded 16-bit LFSR, so runs are reproducible.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new identifier; sampled only in IDLE.
- len  input  5  identifier length, 0..31; sampled with start.
- seed  input  16  LFSR seed; sampled with start.
- ready  input  1  downstream accepts `char` this cycle.
- char  output  8  current ASCII character.
- valid  output  1  `char` is valid.
- last  output  1  current character is the final one of the identifier.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse after the final beat, or after a len=0 request.

## Operation
- States: IDLE, HEAD (first character), BODY (remaining characters).
- IDLE, start=1, len≥2: load lfsr ← seed (seed 0 is replaced by 16'hACE1), cnt ← len−1, go to HEAD.
- IDLE, start=1, len=1: same load, with cnt=0; HEAD is also the last character.
- IDLE, start=1, len=0: stay in IDLE, emit no characters, pulse done on the next cycle.
- Beat: valid && ready. On each beat the LFSR steps once.
  - HEAD beat: if cnt=0, go to IDLE with done; otherwise go to BODY.
  - BODY beat: if cnt=0, go to IDLE with done; otherwise cnt−1.
- LFSR: shifts left, new lsb = l[15]^l[13]^l[12]^l[10].
- Character index: i = lfsr[5:0].
- HEAD mapping: fold i≥52 by subtracting 52. Then 0..25 → 'A'+i; 26..51 → 'a'+(i−26).
- BODY mapping: fold i≥62 by subtracting 62. Then 0..51 use the letter map; 52..61 → '0'+(i−52).
- last = valid && cnt==0.
- start is ignored while busy. len and seed changes after acceptance are ignored.

## Timing
- Reset values: valid=0, last=0, busy=0, done=0, char=8'h00, state=IDLE, lfsr=16'hACE1, cnt=0.
- Start accepted on edge n: valid=1 and busy=1 from cycle n+1.
- Throughput: one character per cycle while ready=1.
- Backpressure: char and last hold stable while valid && !ready; the LFSR does not step.
- Final beat on edge m: valid=0, busy=0, done=1 during cycle m+1; done=0 afterwards.
- A start in that same done cycle is accepted, giving back-to-back identifiers with one idle cycle between them.
- Reset mid-stream: next cycle matches the reset values; no done pulse; the partial identifier is abandoned.
- Reset has priority over start and ready.

## Configuration
- IDENT_UNDERSCORE_EN defined: BODY index 63 maps to '_' (8'h5F); only index 62 folds to 0 ('A').
- IDENT_UNDERSCORE_EN undefined: indices 62 and 63 fold to 'A' and 'B'; the output never contains '_'.
- HEAD never emits '_' in either build.

## Structure
- ident_pkg holds:
  - state encodings IDLE=2'b00, HEAD=2'b01, BODY=2'b10;
  - LFSR_DEFAULT=16'hACE1;
  - ASCII bases 'A', 'a', '0', '_';
  - fold limits 52 and 62.
- Sub-module ident_lfsr: 16-bit LFSR with load, step and zero-seed substitution.
- The FSM, counter and character mapping live in ident_emitter.

## Test plan
- Reset, then start with len=1, seed=16'h0001, ready=1 → exactly one beat, char='B' (8'h42), last=1, done two cycles after start.
- start with len=1, seed=16'h0034 → char='A' (fold 52→0). With seed=16'h0000 → char='h' (ACE1[5:0]=33).
- len=8, random seed, ready=1 → 8 consecutive beats; first char a letter, rest letters/digits; last only on beat 8; busy high for 8 cycles.
- Same run with ready toggled randomly → char held while stalled, exactly 8 beats, same character sequence as the unstalled run.
- len=0 → no valid, done pulse on the next cycle. start while busy → ignored, stream unchanged.
- Reset asserted on beat 3 of len=10 → valid=0 next cycle, no done. Rerun with the same seed reproduces the first 3 characters.

Source files
------------

// File: rtl/ident_pkg.sv
// ident_pkg: shared state encoding, LFSR default seed, ASCII bases and
// character-mapping helpers for the identifier emitter.
// Build option: IDENT_UNDERSCORE_EN lets body characters include '_'.
package ident_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT     = 16'hACE1;

  localparam logic [7:0]  ASCII_UPPER      = 8'h41;
  localparam logic [7:0]  ASCII_LOWER      = 8'h61;
  localparam logic [7:0]  ASCII_DIGIT      = 8'h30;
  localparam logic [7:0]  ASCII_UNDERSCORE = 8'h5F;

  localparam logic [5:0]  HEAD_FOLD        = 6'd52;
  localparam logic [5:0]  BODY_FOLD        = 6'd62;

  // Index 0..51 onto 'A'..'Z' then 'a'..'z'.
  function automatic logic [7:0] letterChar(input logic [5:0] idx);
    if (idx < 6'd26) begin
      return ASCII_UPPER + {2'b00, idx};
    end
    return ASCII_LOWER + {2'b00, idx - 6'd26};
  endfunction

  // First character: letters only, so the top 12 indices wrap onto 'A'..'L'.
  function automatic logic [7:0] headChar(input logic [5:0] idx);
    logic [5:0] folded;
    folded = (idx >= HEAD_FOLD) ? idx - HEAD_FOLD : idx;
    return letterChar(folded);
  endfunction

  // Later characters: letters, then digits at 52..61; 62/63 wrap or give '_'.
  function automatic logic [7:0] bodyChar(input logic [5:0] idx);
    logic [5:0] folded;
    folded = idx;
`ifdef IDENT_UNDERSCORE_EN
    if (idx == 6'd63) begin
      return ASCII_UNDERSCORE;
    end
    if (idx == BODY_FOLD) begin
      folded = 6'd0;
    end
`else
    if (idx >= BODY_FOLD) begin
      folded = idx - BODY_FOLD;
    end
`endif
    if (folded >= HEAD_FOLD) begin
      return ASCII_DIGIT + {2'b00, folded - HEAD_FOLD};
    end
    return letterChar(folded);
  endfunction

endpackage

// File: rtl/ident_lfsr.sv
// ident_lfsr: 16-bit left-shifting LFSR with seed load and single-step
// control. A zero seed would lock the register, so it is replaced by the
// default seed. The low six bits of the upcoming value are exported so the
// caller can register the matching character in the same edge.
module ident_lfsr
  import ident_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [5:0]  nextIdx_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: a load takes precedence over a step; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // State register, returning to the default seed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign nextIdx_o = lfsr_d[5:0];

endmodule

// File: rtl/ident_emitter.sv
// ident_emitter: emits a pseudo-random legal identifier (letter first, then
// letters/digits) one byte per valid/ready beat. All outputs are registered.
// Build option: IDENT_UNDERSCORE_EN adds '_' to the body character set.
module ident_emitter
  import ident_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  len,
  input  logic [15:0] seed,
  input  logic        ready,
  output logic [7:0]  char,
  output logic        valid,
  output logic        last,
  output logic        busy,
  output logic        done
);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic [7:0] char_q;
  logic       valid_q;
  logic       last_q;
  logic       busy_q;
  logic       done_q;

  logic       beat;
  logic       loadSeed;
  logic [5:0] nextIdx;

  assign beat     = valid_q && ready;
  assign loadSeed = (state_q == IDLE) && start && (len != 5'd0);

  ident_lfsr u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (loadSeed),
    .step_i    (beat),
    .seed_i    (seed),
    .nextIdx_o (nextIdx)
  );

  // Sequencer: accepts requests, counts remaining characters and registers
  // the character that matches the LFSR value it is about to hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= HEAD;
              cnt_q   <= len - 5'd1;
              char_q  <= headChar(nextIdx);
              valid_q <= 1'b1;
              last_q  <= (len == 5'd1);
              busy_q  <= 1'b1;
            end
          end
        end
        HEAD, BODY: begin
          if (beat) begin
            if (cnt_q == 5'd0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= BODY;
              cnt_q   <= cnt_q - 5'd1;
              char_q  <= bodyChar(nextIdx);
              last_q  <= (cnt_q == 5'd1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign char  = char_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ident_emitter.sv
// tb_ident_emitter: directed bench for ident_emitter. Inputs are driven and
// outputs sampled on the falling edge; a reference LFSR and a string lookup
// table predict every character.
// Build option: IDENT_UNDERSCORE_EN changes the expected body character set.
module tb_ident_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  len;
  logic [15:0] seed;
  logic        ready;
  logic [7:0]  char;
  logic        valid;
  logic        last;
  logic        busy;
  logic        done;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] capture [32];
  logic [7:0] saved   [32];
  int         beatsSeen;

  string alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";

  always #5 clk = ~clk;

  ident_emitter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .seed  (seed),
    .ready (ready),
    .char  (char),
    .valid (valid),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] modelHead(input logic [5:0] idx);
    int k;
    k = int'(idx) % 52;
    return alphabet[k];
  endfunction

  function automatic logic [7:0] modelBody(input logic [5:0] idx);
    int k;
`ifdef IDENT_UNDERSCORE_EN
    if (idx == 6'd63) return 8'h5F;
`endif
    k = int'(idx) % 62;
    return alphabet[k];
  endfunction

  function automatic bit isLetter(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic bit isBodyChar(input logic [7:0] c);
`ifdef IDENT_UNDERSCORE_EN
    if (c == 8'h5F) return 1'b1;
`endif
    return isLetter(c) || (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Present one start request; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [4:0] n, input logic [15:0] s);
    start = 1'b1;
    len   = n;
    seed  = s;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one identifier, checking every visible character against the model.
  task automatic runIdent(input logic [4:0] n, input logic [15:0] s, input bit stall,
                          input bit poke, input int abortAt, input string tag);
    logic [15:0] m;
    int k;
    int cycles;
    int busyCycles;
    m = (s == 16'h0000) ? 16'hACE1 : s;
    k = 0;
    cycles = 0;
    busyCycles = 0;
    applyStimulus(n, s);
    checkOutput({tag, "_first_valid"}, {31'd0, valid}, 32'd1);
    checkOutput({tag, "_first_busy"}, {31'd0, busy}, 32'd1);
    while (k < int'(n) && cycles < 300) begin
      if (busy) busyCycles++;
      checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd1);
      checkOutput({tag, "_char"}, {24'd0, char}, {24'd0, (k == 0) ? modelHead(m[5:0]) : modelBody(m[5:0])});
      checkOutput({tag, "_last"}, {31'd0, last}, {31'd0, k == int'(n) - 1});
      if (k == abortAt) begin
        capture[k] = char;
        reset = 1'b1;
        ready = 1'b1;
        break;
      end
      ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && k == 1) begin
        start = 1'b1;
        len   = 5'd7;
        seed  = 16'h5555;
      end else begin
        start = 1'b0;
      end
      if (ready) begin
        capture[k] = char;
        k++;
        m = modelStep(m);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    beatsSeen = k;
    if (k == abortAt) begin
      @(negedge clk);
      checkOutput({tag, "_rst_valid"}, {31'd0, valid}, 32'd0);
      checkOutput({tag, "_rst_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_rst_char"}, {24'd0, char}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_rst_done_after"}, {31'd0, done}, 32'd0);
    end else begin
      checkOutput({tag, "_no_timeout"}, {31'd0, cycles < 300}, 32'd1);
      checkOutput({tag, "_end_valid"}, {31'd0, valid}, 32'd0);
      checkOutput({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_end_done"}, {31'd0, done}, 32'd1);
      if (!stall) checkOutput({tag, "_busy_cycles"}, busyCycles, {27'd0, n});
      @(negedge clk);
      checkOutput({tag, "_done_clear"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_idle_valid"}, {31'd0, valid}, 32'd0);
    end
  endtask

  initial begin
    int rnd;
    logic [15:0] seedR;
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    len   = 5'd0;
    seed  = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_last", {31'd0, last}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_char", {24'd0, char}, 32'd0);
    reset = 1'b0;

    runIdent(5'd1, 16'h0001, 1'b0, 1'b0, 99, "len1_seed1");
    checkOutput("len1_seed1_B", {24'd0, capture[0]}, 32'h42);
    runIdent(5'd1, 16'h0034, 1'b0, 1'b0, 99, "len1_fold52");
    checkOutput("len1_fold52_A", {24'd0, capture[0]}, 32'h41);
    runIdent(5'd1, 16'h0000, 1'b0, 1'b0, 99, "len1_seed0");
    checkOutput("len1_seed0_h", {24'd0, capture[0]}, 32'h68);
    runIdent(5'd1, 16'h003F, 1'b0, 1'b0, 99, "head_idx63");
    checkOutput("head_idx63_L", {24'd0, capture[0]}, 32'h4C);
    runIdent(5'd2, 16'h0001, 1'b0, 1'b0, 99, "len2");
    checkOutput("len2_second_C", {24'd0, capture[1]}, 32'h43);
    runIdent(5'd2, 16'h001F, 1'b0, 1'b0, 99, "body_idx62");
    checkOutput("body_idx62_A", {24'd0, capture[1]}, 32'h41);
    runIdent(5'd2, 16'h041F, 1'b0, 1'b0, 99, "body_idx63");
`ifdef IDENT_UNDERSCORE_EN
    checkOutput("body_idx63_us", {24'd0, capture[1]}, 32'h5F);
`else
    checkOutput("body_idx63_B", {24'd0, capture[1]}, 32'h42);
`endif

    rnd = $urandom_range(1, 65535);
    seedR = rnd[15:0];
    runIdent(5'd8, seedR, 1'b0, 1'b0, 99, "len8");
    checkOutput("len8_beats", beatsSeen, 32'd8);
    checkOutput("len8_head_letter", {31'd0, isLetter(capture[0])}, 32'd1);
    for (int i = 1; i < 8; i++) checkOutput("len8_body_legal", {31'd0, isBodyChar(capture[i])}, 32'd1);
    for (int i = 0; i < 8; i++) saved[i] = capture[i];

    runIdent(5'd8, seedR, 1'b1, 1'b0, 99, "len8_stall");
    checkOutput("len8_stall_beats", beatsSeen, 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("len8_stall_same", {24'd0, capture[i]}, {24'd0, saved[i]});

    applyStimulus(5'd0, 16'h1234);
    checkOutput("len0_valid", {31'd0, valid}, 32'd0);
    checkOutput("len0_busy", {31'd0, busy}, 32'd0);
    checkOutput("len0_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput("len0_done_clear", {31'd0, done}, 32'd0);
    checkOutput("len0_still_idle", {31'd0, valid}, 32'd0);

    runIdent(5'd6, 16'hBEEF, 1'b0, 1'b1, 99, "busy_start");
    checkOutput("busy_start_beats", beatsSeen, 32'd6);

    runIdent(5'd10, 16'h4C1D, 1'b0, 1'b0, 2, "abort");
    for (int i = 0; i < 3; i++) saved[i] = capture[i];
    runIdent(5'd10, 16'h4C1D, 1'b0, 1'b0, 99, "rerun");
    for (int i = 0; i < 3; i++) checkOutput("rerun_prefix", {24'd0, capture[i]}, {24'd0, saved[i]});

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
